// File: rtl/add_sub_job_ctrl.sv
// Job controller for the 128-bit add_sub stream kernel.
// Two requesters submit {op, beat count} jobs. A round-robin arbiter picks
// one job at a time. For that job the block holds kern_op and the stream-mux
// select, issues exactly `count` kernel invocations through the
// ap_start/ap_done handshake, and reports one completion pulse per job.
module add_sub_job_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic [1:0]         req_valid,
   input  logic [1:0]         req_op,
   input  logic [2*CNT_W-1:0] req_count,
   output logic [1:0]         req_ready,
   input  logic               abort,
   output logic               kern_ap_start,
   output logic               kern_op,
   input  logic               kern_ap_done,
   input  logic               kern_ap_idle,
   output logic               sel,
   output logic               busy,
   output logic               done,
   output logic               done_id,
   output logic               done_aborted,
   output logic [CNT_W-1:0]   done_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] job_cnt_r;
   logic [CNT_W-1:0] beat_cnt_r;
   logic             kern_op_r;
   logic             sel_r;
   logic             rr_last_r;
   logic             aborted_r;
   logic             active_r;

   logic             grant_vld_s;
   logic             grant_id_s;
   logic             grant_op_s;
   logic [CNT_W-1:0] grant_cnt_s;
   logic             accept_s;
   logic             last_beat_s;
   logic             counting_s;

   // Round-robin pick: a lone request wins, a tie goes to the requester that was not served last.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
      case (req_valid)
         2'b01: begin
            grant_vld_s = 1'b1;
            grant_id_s  = 1'b0;
         end
         2'b10: begin
            grant_vld_s = 1'b1;
            grant_id_s  = 1'b1;
         end
         2'b11: begin
            grant_vld_s = 1'b1;
            grant_id_s  = ~rr_last_r;
         end
         default: begin
            grant_vld_s = 1'b0;
            grant_id_s  = 1'b0;
         end
      endcase
   end

   // Select the granted requester's job descriptor.
   always_comb begin
      grant_op_s = req_op[grant_id_s];
      if (grant_id_s) begin
         grant_cnt_s = req_count[CNT_W +: CNT_W];
      end else begin
         grant_cnt_s = req_count[0 +: CNT_W];
      end
   end

   // A job is taken only in IDLE, and never in the first cycle out of reset
   // so that req_ready stays low for as long as the block is held in reset.
   assign accept_s    = (state_r == IDLE) && grant_vld_s && active_r;
   assign counting_s  = (state_r == RUN) || (state_r == DRAIN);
   // job_cnt_r is never zero in RUN, so the decrement cannot wrap here.
   assign last_beat_s = kern_ap_done && (beat_cnt_r == (job_cnt_r - CNT_ONE));

   // Next-state logic for the job sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (grant_cnt_s == CNT_ZERO) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = RUN;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            // A final ap_done wins over a coincident abort: the job is complete.
            if (last_beat_s) begin
               state_nxt_s = DONE;
            end else if (abort) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            if (kern_ap_idle) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Marks the block as out of reset; gates acceptance of the first job.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         active_r <= 1'b0;
      end else begin
         active_r <= 1'b1;
      end
   end

   // Job descriptor latch: op, select and arbitration history change only on accept.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         kern_op_r <= 1'b0;
         sel_r     <= 1'b0;
         rr_last_r <= 1'b1;
         job_cnt_r <= CNT_ZERO;
      end else if (accept_s) begin
         kern_op_r <= grant_op_s;
         sel_r     <= grant_id_s;
         rr_last_r <= grant_id_s;
         job_cnt_r <= grant_cnt_s;
      end else begin
         kern_op_r <= kern_op_r;
         sel_r     <= sel_r;
         rr_last_r <= rr_last_r;
         job_cnt_r <= job_cnt_r;
      end
   end

   // Beat counter: cleared on accept, counts every ap_done seen in RUN or DRAIN.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         beat_cnt_r <= CNT_ZERO;
      end else if (accept_s) begin
         beat_cnt_r <= CNT_ZERO;
      end else if (counting_s && kern_ap_done) begin
         beat_cnt_r <= beat_cnt_r + CNT_ONE;
      end else begin
         beat_cnt_r <= beat_cnt_r;
      end
   end

   // Aborted flag: set when a drained job retires, cleared as DONE hands back to IDLE.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         aborted_r <= 1'b0;
      end else if ((state_r == DRAIN) && kern_ap_idle) begin
         aborted_r <= 1'b1;
      end else if (state_r == DONE) begin
         aborted_r <= 1'b0;
      end else begin
         aborted_r <= aborted_r;
      end
   end

   // Output decode; completion fields read zero except during the DONE cycle.
   always_comb begin
      req_ready     = 2'b00;
      kern_ap_start = (state_r == RUN);
      kern_op       = kern_op_r;
      sel           = sel_r;
      busy          = (state_r != IDLE);
      done          = (state_r == DONE);
      done_id       = 1'b0;
      done_aborted  = 1'b0;
      done_count    = CNT_ZERO;
      if (accept_s) begin
         req_ready = grant_id_s ? 2'b10 : 2'b01;
      end else begin
         req_ready = 2'b00;
      end
      if (state_r == DONE) begin
         done_id      = sel_r;
         done_aborted = aborted_r;
         done_count   = beat_cnt_r;
      end else begin
         done_id      = 1'b0;
         done_aborted = 1'b0;
         done_count   = CNT_ZERO;
      end
   end

endmodule
